// File: rtl/n_bit_up_counter_if.sv
// n_bit_up_counter_if -- control/status bundle for n_bit_up_counter.
//   Parameter N     : counter width in bits (N >= 2).
//   en              : count enable.
//   load / load_val : synchronous load strobe and the value to load.
//   max_val         : terminal count, the highest value the counter reaches.
//   wrap_en         : 1 = wrap to 0 after max_val, 0 = saturate at max_val.
//   count_out       : registered counter value.
//   done            : high while count_out >= max_val (combinational).
//   wrap_pulse      : one-cycle pulse after each wrap to 0.
//   ovf             : sticky flag, increment attempted while saturated.
// The master modport drives the controls; the slave modport is the counter.
interface n_bit_up_counter_if #(
  parameter int unsigned N = 3
);
  logic         en;
  logic         load;
  logic [N-1:0] load_val;
  logic [N-1:0] max_val;
  logic         wrap_en;
  logic [N-1:0] count_out;
  logic         done;
  logic         wrap_pulse;
  logic         ovf;

  modport master (
    output en, load, load_val, max_val, wrap_en,
    input  count_out, done, wrap_pulse, ovf
  );

  modport slave (
    input  en, load, load_val, max_val, wrap_en,
    output count_out, done, wrap_pulse, ovf
  );
endinterface

// File: rtl/n_bit_up_counter.sv
// n_bit_up_counter -- up counter with programmable terminal count.
//   clk : clock, all state updates on the rising edge.
//   rst : synchronous, active-high reset (clears count, wrap_pulse, ovf).
//   bus : n_bit_up_counter_if slave modport carrying the enable, load,
//         load value, terminal count, wrap mode and the count/status outputs.
// Per-edge priority is rst > load > en > hold.
module n_bit_up_counter #(
  parameter int unsigned N = 3
) (
  input logic               clk,
  input logic               rst,
  n_bit_up_counter_if.slave bus
);

  localparam logic [N-1:0] ONE = N'(1);

  logic [N-1:0] count_q;
  logic         wrap_q;
  logic         ovf_q;

  logic         at_max;
  logic [N-1:0] load_clamped;

  always_comb begin
    // ">=" rather than "==" so a max_val lowered under the current count
    // is treated as terminal immediately.
    at_max       = (count_q >= bus.max_val);
    load_clamped = (bus.load_val > bus.max_val) ? bus.max_val : bus.load_val;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
      wrap_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else if (bus.load) begin
      count_q <= load_clamped;
      wrap_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else if (bus.en) begin
      if (!at_max) begin
        // Increment only happens below max_val, so it can never carry out.
        count_q <= count_q + ONE;
        wrap_q  <= 1'b0;
      end else if (bus.wrap_en) begin
        count_q <= '0;
        wrap_q  <= 1'b1;
      end else begin
        wrap_q  <= 1'b0;
        ovf_q   <= 1'b1;
      end
    end else begin
      wrap_q <= 1'b0;
    end
  end

  assign bus.count_out  = count_q;
  assign bus.wrap_pulse = wrap_q;
  assign bus.ovf        = ovf_q;
  assign bus.done       = at_max;

endmodule
